// File: rtl/cpu_control_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, FSM states,
// branch condition codes and register-file write-source selects.
package cpu_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_PC  = 2'b10;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return !op[3];
    endfunction

endpackage

// File: rtl/cpu_control_branch_cond.sv
// Branch condition evaluation from a 3-bit condition code and {Z,V,N} flags.
module branch_cond
    import cpu_control_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLAG_Z];
    assign w_v = flags[FLAG_V];
    assign w_n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:   taken = !w_z;
            CC_EQ:   taken = w_z;
            CC_GT:   taken = !w_z && !w_n;
            CC_LT:   taken = w_n;
            CC_GE:   taken = w_z || !w_n;
            CC_LE:   taken = w_z || w_n;
            CC_OV:   taken = w_v;
            CC_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing,
// PC and instruction register, condition flags and sticky ALU fault.
module cpu_control
    import cpu_control_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [3:0]        alu_opcode,
    input  logic [2:0]        alu_flags,
    input  logic              alu_err,
    output logic [3:0]        rf_raddr1,
    output logic [3:0]        rf_raddr2,
    input  logic [15:0]       rf_rdata1,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [1:0]        rf_wsel,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] pc_plus2,
    output logic              halted,
    output logic              fault
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [2:0]        r_flags;
    logic              r_fault;

    logic [3:0]        w_op;
    logic              w_taken;
    logic [ADDR_W-1:0] w_pc_plus2;
    logic [ADDR_W-1:0] w_br_off;

    assign w_op       = r_ir[15:12];
    assign w_pc_plus2 = r_pc + ADDR_W'(2);
    // 9-bit word offset, sign-extended and scaled to bytes
    assign w_br_off   = {{(ADDR_W-10){r_ir[8]}}, r_ir[8:0], 1'b0};

    branch_cond u_branch_cond (
        .ccc   (r_ir[11:9]),
        .flags (r_flags),
        .taken (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (imem_ready) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_LW, OP_SW: w_next = S_MEM;
                    OP_B, OP_BR:  w_next = S_FETCH;
                    OP_HLT:       w_next = S_HALT;
                    default:      w_next = S_WB;
                endcase
            end
            S_MEM:    if (dmem_ready) w_next = (w_op == OP_SW) ? S_FETCH : S_WB;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        alu_opcode = 4'h0;
        rf_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        halted     = 1'b0;
        rf_wsel    = WSEL_ALU;
        case (r_state)
            // Gated by rst_n so no fetch request is visible while held in reset
            S_FETCH: imem_req = rst_n;
            S_EXEC: begin
                if (is_alu_op(w_op) || w_op == OP_LLB || w_op == OP_LHB) begin
                    alu_opcode = w_op;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (w_op == OP_SW);
            end
            S_WB:    rf_we  = 1'b1;
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        if (w_op == OP_LW) begin
            rf_wsel = WSEL_MEM;
        end else if (w_op == OP_PCS) begin
            rf_wsel = WSEL_PC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_flags <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: if (imem_ready) r_ir <= imem_rdata;
                S_EXEC: begin
                    if (alu_err) r_fault <= 1'b1;
                    case (w_op)
                        OP_ADD, OP_SUB: r_flags <= alu_flags;
                        OP_XOR, OP_SLL, OP_SRA, OP_ROR: r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
                        OP_B:  r_pc <= w_taken ? (w_pc_plus2 + w_br_off) : w_pc_plus2;
                        OP_BR: r_pc <= w_taken ? ADDR_W'(rf_rdata1) : w_pc_plus2;
                        default: ;
                    endcase
                end
                S_MEM:   if (dmem_ready && w_op == OP_SW) r_pc <= w_pc_plus2;
                S_WB:    r_pc <= w_pc_plus2;
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign pc_plus2  = w_pc_plus2;
    assign rf_raddr1 = r_ir[7:4];
    assign rf_raddr2 = r_ir[3:0];
    assign rf_waddr  = r_ir[11:8];
    assign fault     = r_fault;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: the bench plays instruction memory, ALU,
// register file and data memory, and checks handshakes, PC flow and flags.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [3:0]  alu_opcode;
    logic [2:0]  alu_flags;
    logic        alu_err;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [1:0]  rf_wsel;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic [15:0] pc_plus2;
    logic        halted;
    logic        fault;

    int n_cmp = 0;
    int n_err = 0;

    cpu_control #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .alu_opcode (alu_opcode),
        .alu_flags  (alu_flags),
        .alu_err    (alu_err),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wsel    (rf_wsel),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .pc_plus2   (pc_plus2),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the fetch request, hand over one instruction, and stop in EXEC
    task automatic fetch(input logic [15:0] instr, input logic [15:0] pc_exp, input string tag);
        chk_val({tag, "_imem_req"}, 32'(imem_req), 32'd1);
        chk_val({tag, "_imem_addr"}, 32'(imem_addr), 32'(pc_exp));
        imem_rdata = instr;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rdata = '0;
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_rdata = '0;
        imem_ready = 1'b0;
        alu_flags  = '0;
        alu_err    = 1'b0;
        rf_rdata1  = '0;
        dmem_ready = 1'b0;
        repeat (3) tick();

        chk_val("rst_imem_req", 32'(imem_req), 32'd0);
        chk_val("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk_val("rst_rf_we", 32'(rf_we), 32'd0);
        chk_val("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk_val("rst_halted", 32'(halted), 32'd0);
        chk_val("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
        #1;

        // ADD r1,r2,r3 at 0: writeback in the fourth cycle, next fetch at 2
        fetch(16'h0123, 16'h0000, "add");
        chk_val("add_raddr1", 32'(rf_raddr1), 32'd2);
        chk_val("add_raddr2", 32'(rf_raddr2), 32'd3);
        chk_val("add_rf_we_exec", 32'(rf_we), 32'd0);
        tick();
        chk_val("add_rf_we", 32'(rf_we), 32'd1);
        chk_val("add_waddr", 32'(rf_waddr), 32'd1);
        chk_val("add_wsel", 32'(rf_wsel), 32'd0);
        tick();
        chk_val("add_rf_we_off", 32'(rf_we), 32'd0);

        // SUB producing zero sets Z
        fetch(16'h1456, 16'h0002, "sub");
        chk_val("sub_opcode", 32'(alu_opcode), 32'h1);
        alu_flags = 3'b100;
        tick();
        chk_val("sub_waddr", 32'(rf_waddr), 32'd4);
        alu_flags = 3'b000;
        tick();

        // B EQ +4 words at PC 4 -> 6 + 8 = 0x000E
        fetch(16'hC204, 16'h0004, "beq");
        chk_val("beq_opcode", 32'(alu_opcode), 32'h0);
        tick();
        chk_val("beq_rf_we", 32'(rf_we), 32'd0);

        // B NE with Z set falls through to 0x0010
        fetch(16'hC004, 16'h000E, "bne");
        tick();

        // LW with three MEM cycles, ready in the third
        fetch(16'h8512, 16'h0010, "lw");
        chk_val("lw_opcode", 32'(alu_opcode), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_val($sformatf("lw_dmem_req%0d", i), 32'(dmem_req), 32'd1);
            chk_val($sformatf("lw_dmem_we%0d", i), 32'(dmem_we), 32'd0);
            chk_val($sformatf("lw_rf_we%0d", i), 32'(rf_we), 32'd0);
            if (i == 2) dmem_ready = 1'b1;
            tick();
        end
        dmem_ready = 1'b0;
        chk_val("lw_rf_we", 32'(rf_we), 32'd1);
        chk_val("lw_wsel", 32'(rf_wsel), 32'd1);
        chk_val("lw_waddr", 32'(rf_waddr), 32'd5);
        chk_val("lw_dmem_req_off", 32'(dmem_req), 32'd0);
        tick();
        chk_val("lw_rf_we_off", 32'(rf_we), 32'd0);

        // XOR updates only Z (V/N from ALU must be ignored); ALU error is sticky
        fetch(16'h2123, 16'h0012, "xor");
        chk_val("xor_opcode", 32'(alu_opcode), 32'h2);
        alu_flags = 3'b011;
        alu_err   = 1'b1;
        tick();
        alu_flags = 3'b000;
        alu_err   = 1'b0;
        chk_val("xor_fault", 32'(fault), 32'd1);
        tick();
        chk_val("xor_fault_sticky", 32'(fault), 32'd1);

        // B GT -1 word at 0x14: Z=0,N=0 so taken -> 0x16 - 2 = 0x14
        fetch(16'hC5FF, 16'h0014, "bgt");
        tick();

        // PCS writes PC+2 into r7
        fetch(16'hE700, 16'h0014, "pcs");
        tick();
        chk_val("pcs_rf_we", 32'(rf_we), 32'd1);
        chk_val("pcs_wsel", 32'(rf_wsel), 32'd2);
        chk_val("pcs_waddr", 32'(rf_waddr), 32'd7);
        chk_val("pcs_pc_plus2", 32'(pc_plus2), 32'h0016);
        tick();

        // BR always to register value 0xFFFE
        fetch(16'hDE30, 16'h0016, "br");
        chk_val("br_raddr1", 32'(rf_raddr1), 32'd3);
        rf_rdata1 = 16'hFFFE;
        tick();
        rf_rdata1 = '0;

        // XOR at 0xFFFE: PC+2 wraps to 0
        fetch(16'h2123, 16'hFFFE, "xorwrap");
        chk_val("wrap_pc_plus2", 32'(pc_plus2), 32'h0000);
        tick();
        tick();

        // SW interrupted by reset during MEM
        fetch(16'h9123, 16'h0000, "sw");
        tick();
        chk_val("sw_dmem_req", 32'(dmem_req), 32'd1);
        chk_val("sw_dmem_we", 32'(dmem_we), 32'd1);
        tick();
        chk_val("sw_dmem_req_hold", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_val("swrst_dmem_req", 32'(dmem_req), 32'd0);
        chk_val("swrst_dmem_we", 32'(dmem_we), 32'd0);
        chk_val("swrst_rf_we", 32'(rf_we), 32'd0);
        chk_val("swrst_fault", 32'(fault), 32'd0);
        chk_val("swrst_imem_req", 32'(imem_req), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;

        // B always +2 words from 0 -> 6, then HLT at 6
        fetch(16'hCE02, 16'h0000, "bal");
        tick();
        fetch(16'hF000, 16'h0006, "hlt");
        tick();
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk_val($sformatf("hlt_halted%0d", i), 32'(halted), 32'd1);
            chk_val($sformatf("hlt_imem_req%0d", i), 32'(imem_req), 32'd0);
            chk_val($sformatf("hlt_pc%0d", i), 32'(imem_addr), 32'h0006);
            tick();
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
